// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button conditioning path: FSM state encoding
// and the default debounce window for a 50 MHz system clock.
package debounce_pkg;

  localparam int CLK_HZ                = 50_000_000;
  localparam int DEBOUNCE_MS           = 5;
  localparam int DEFAULT_STABLE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; RESET_VAL is the level
// both flops return to on reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= RESET_VAL;
      r_s2 <= RESET_VAL;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule

// File: rtl/button_debouncer.sv
// Synchronises and debounces one raw button; emits a registered pressed level
// plus single-cycle rise/fall strobes.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = 18,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_clean,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             w_sync;
  logic             w_in;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_clean, w_clean_nxt;
  logic             r_rise, w_rise_nxt;
  logic             r_fall, w_fall_nxt;

  sync_2ff #(.RESET_VAL(ACTIVE_LOW)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (w_sync)
  );

  // Normalise so that 1 always means pressed.
  assign w_in = w_sync ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_clean <= w_clean_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // The level check is evaluated before the terminal count, so a bounce on the
  // completing cycle still rejects the transition.
  always_comb begin
    w_state_nxt = IDLE_LOW;
    w_cnt_nxt   = '0;
    w_clean_nxt = 1'b0;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      IDLE_LOW: begin
        if (w_in) begin
          w_state_nxt = WAIT_HIGH;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (!w_in) begin
          w_state_nxt = IDLE_LOW;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE_HIGH;
          w_clean_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_state_nxt = WAIT_HIGH;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        w_clean_nxt = 1'b1;
        if (!w_in) begin
          w_state_nxt = WAIT_LOW;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_state_nxt = IDLE_HIGH;
        end
      end
      WAIT_LOW: begin
        if (w_in) begin
          w_state_nxt = IDLE_HIGH;
          w_clean_nxt = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE_LOW;
          w_fall_nxt  = 1'b1;
        end else begin
          w_state_nxt = WAIT_LOW;
          w_clean_nxt = 1'b1;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE_LOW;
      end
    endcase
  end

  assign btn_clean = r_clean;
  assign rise      = r_rise;
  assign fall      = r_fall;

endmodule

// File: tb/tb_button_debouncer.sv
// Scenario bench for button_debouncer with a 4-sample window and active-low input.
module tb_button_debouncer;
  import debounce_pkg::*;

  localparam int STABLE = 4;
  // Accepted edge is the LAT-th edge after the one at which s1 captures the level.
  localparam int LAT    = STABLE + 1;

  typedef struct {
    logic  clean;
    logic  rise;
    logic  fall;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic btn_raw;
  logic btn_clean, rise, fall;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  button_debouncer #(.STABLE_CYCLES(STABLE), .CNT_W(3), .ACTIVE_LOW(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .btn_clean (btn_clean),
    .rise      (rise),
    .fall      (fall)
  );

  always #5 clk = ~clk;

  // Scoreboard: every driven cycle pushed one expectation for the following edge.
  always @(posedge clk) begin
    #2;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if ({btn_clean, rise, fall} !== {e.clean, e.rise, e.fall}) begin
        n_err++;
        $display("FAIL %s t=%0t got clean/rise/fall=%b%b%b want %b%b%b",
                 e.tag, $time, btn_clean, rise, fall, e.clean, e.rise, e.fall);
      end
    end
  end

  task automatic drive(input logic raw, input logic rst,
                       input logic c, input logic r, input logic f, input string tag);
    exp_t e;
    @(negedge clk);
    btn_raw = raw;
    reset   = rst;
    e.clean = c; e.rise = r; e.fall = f; e.tag = tag;
    sb.push_back(e);
  endtask

  // Press (raw=0) held from a released, settled state.
  task automatic press_held(input string tag);
    for (int k = 1; k <= LAT + 2; k++) begin
      if (k < LAT + 1)       drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
      else if (k == LAT + 1) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, tag);
      else                   drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, tag);
    end
  endtask

  task automatic release_held(input string tag);
    for (int k = 1; k <= LAT + 2; k++) begin
      if (k < LAT + 1)       drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, tag);
      else if (k == LAT + 1) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, tag);
      else                   drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "reset_hold");
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset_after");
  endtask

  task automatic test_clean_press();
    press_held("press");
  endtask

  task automatic test_release();
    release_held("release");
  endtask

  task automatic test_bounce();
    for (int rep = 0; rep < 4; rep++) begin
      for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "bounce_low");
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "bounce_high");
    end
    for (int k = 0; k < LAT + 2; k++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "bounce_tail");
  endtask

  task automatic test_reset_mid_count();
    // Edges 1..4 pressed: cnt reaches 2 after edge 4.
    for (int k = 1; k <= 4; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "midrst_count");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "midrst_reset");
    @(posedge clk);
    #3;
    n_vec++;
    if (dut.r_state !== IDLE_LOW || dut.r_cnt !== 3'd0) begin
      n_err++;
      $display("FAIL midrst_state got state=%0d cnt=%0d want state=0 cnt=0",
               dut.r_state, dut.r_cnt);
    end
    // Still pressed after reset: the full latency applies again.
    press_held("midrst_repress");
    release_held("midrst_release");
  endtask

  task automatic test_late_bounce();
    // Three pressed samples bring cnt to 3, then one released sample at the terminal cycle.
    for (int k = 1; k <= 3; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "late_count");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "late_glitch");
    n_vec++;
    if (dut.r_state !== IDLE_LOW && dut.r_state !== WAIT_HIGH) begin
      n_err++;
      $display("FAIL late_state got state=%0d want IDLE_LOW/WAIT_HIGH", dut.r_state);
    end
    // New press from edge 5 is accepted only at edge 5+LAT.
    for (int k = 5; k <= 4 + LAT + 2; k++) begin
      if (k < 5 + LAT)       drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "late_repress");
      else if (k == 5 + LAT) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "late_repress");
      else                   drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "late_repress");
    end
    release_held("late_release");
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = 1'b1;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_reset_mid_count();
    test_late_bounce();
    repeat (3) @(posedge clk);
    #3;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
